// File: rtl/bf_uart_tx.sv
// bf_uart_tx: FIFO-buffered UART transmitter for the brainfuck core's character output (8N1, LSB first).
// Define BF_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
module bf_uart_tx #(
    parameter int CLK_PER_BIT     = 16,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sendingChar,
    input  logic [7:0] sendedChar,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       overflow
);
    localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
    localparam int BAUD_W = $clog2(CLK_PER_BIT);
    localparam int CNT_W  = FIFO_DEPTH_LOG2 + 1;
    localparam logic [BAUD_W-1:0]          BAUD_RELOAD = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [BAUD_W-1:0]          BAUD_ONE    = BAUD_W'(1);
    localparam logic [CNT_W-1:0]           CNT_FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]           CNT_ONE     = CNT_W'(1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE     = FIFO_DEPTH_LOG2'(1);

`ifdef BF_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                     state, state_nx;
    logic [BAUD_W-1:0]          baud, baud_nx;
    logic [2:0]                 bit_idx, bit_idx_nx;
    logic [7:0]                 shift;
    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       pop, push_ok, shift_en, tx_nx;
    logic                       fifo_nempty, baud_done;
`ifdef BF_UART_TX_PARITY_EN
    logic                       parity_bit;
`endif

    assign fifo_nempty = (count != '0);
    assign baud_done   = (baud == '0);
    assign full        = (count == CNT_FULL);
    // A full FIFO still takes a push when the serialiser pops in the same cycle.
    assign push_ok     = sendingChar && (!full || pop);

    always_comb begin
        state_nx   = state;
        baud_nx    = baud;
        bit_idx_nx = bit_idx;
        pop        = 1'b0;
        shift_en   = 1'b0;
        tx_nx      = 1'b1;
        case (state)
            IDLE: begin
                if (fifo_nempty) begin
                    pop      = 1'b1;
                    baud_nx  = BAUD_RELOAD;
                    state_nx = START;
                end
            end
            START: begin
                tx_nx   = 1'b0;
                baud_nx = baud - BAUD_ONE;
                if (baud_done) begin
                    baud_nx  = BAUD_RELOAD;
                    state_nx = DATA;
                end
            end
            DATA: begin
                tx_nx   = shift[0];
                baud_nx = baud - BAUD_ONE;
                if (baud_done) begin
                    baud_nx    = BAUD_RELOAD;
                    shift_en   = 1'b1;
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef BF_UART_TX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
            end
`ifdef BF_UART_TX_PARITY_EN
            PARITY: begin
                tx_nx   = parity_bit;
                baud_nx = baud - BAUD_ONE;
                if (baud_done) begin
                    baud_nx  = BAUD_RELOAD;
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                tx_nx   = 1'b1;
                baud_nx = baud - BAUD_ONE;
                // Pending bytes chain straight into the next start bit.
                if (baud_done) begin
                    if (fifo_nempty) begin
                        pop      = 1'b1;
                        baud_nx  = BAUD_RELOAD;
                        state_nx = START;
                    end else begin
                        baud_nx  = '0;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // busy is registered next to tx so it still covers the last stop bit on the line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            baud    <= baud_nx;
            bit_idx <= bit_idx_nx;
            tx      <= tx_nx;
            busy    <= (state != IDLE) || fifo_nempty;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (sendingChar && !push_ok) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= sendedChar;
        if (pop) shift <= mem[rd_ptr];
        else if (shift_en) shift <= {1'b0, shift[7:1]};
`ifdef BF_UART_TX_PARITY_EN
        if (pop) parity_bit <= ^mem[rd_ptr];
`endif
    end

endmodule
